// File: rtl/spike_array_serial_acc_if.sv
// Handshake bundle for the bit-serial spike dot-product array.
// The master side feeds vectors and accepts results; the slave side is the array.
interface spike_array_serial_acc_if #(
  parameter int N     = 128,
  parameter int WBITS = 4,
  parameter int ABITS = 4,
  parameter int ACC_W = 24
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic [N*WBITS-1:0]      i_weights_flat;
  logic [N*ABITS-1:0]      i_acts_flat;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    ovf;

  modport master (
    output in_valid, in_last, i_weights_flat, i_acts_flat, out_ready,
    input  in_ready, out_valid, out_data, ovf
  );

  modport slave (
    input  in_valid, in_last, i_weights_flat, i_acts_flat, out_ready,
    output in_ready, out_valid, out_data, ovf
  );
endinterface

// File: rtl/spike_array_serial_acc.sv
// Bit-serial dot product: one activation magnitude bit-plane per cycle goes through a shared
// pipelined adder tree and is shift-accumulated into a signed, optionally saturating accumulator.
module spike_array_serial_acc_lane #(
  parameter int WBITS = 4,
  parameter int ABITS = 4,
  parameter int PW    = 2,
  parameter int TW    = 12
) (
  input  logic signed [WBITS-1:0] w,
  input  logic signed [ABITS-1:0] a,
  input  logic [PW-1:0]           plane,
  output logic signed [TW-1:0]    part
);
  logic [ABITS-1:0]   mag;
  logic signed [WBITS:0] wx, p;

  // |a| fits ABITS unsigned bits, including the most negative code
  always_comb begin
    mag  = a[ABITS-1] ? ABITS'(-a) : a;
    wx   = {w[WBITS-1], w};
    p    = mag[plane] ? (a[ABITS-1] ? -wx : wx) : '0;
    part = {{(TW-WBITS-1){p[WBITS]}}, p};
  end
endmodule

module spike_array_serial_acc #(
  parameter int N     = 128,
  parameter int WBITS = 4,
  parameter int ABITS = 4,
  parameter int ACC_W = 24,
  parameter int SAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spike_array_serial_acc_if.slave bus
);
  localparam int L  = $clog2(N);
  localparam int TW = WBITS + 1 + L;
  localparam int PW = (ABITS > 1) ? $clog2(ABITS) : 1;
  localparam int CW = $clog2(ABITS + L + 2) + 1;
  localparam int XW = ACC_W + TW + ABITS;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt;
  logic [N-1:0][WBITS-1:0] w_q;
  logic [N-1:0][ABITS-1:0] a_q;
  logic                    last_q, dp_open, accept, issue;
  logic                    in_ready_q, out_valid_q, ovf_q;
  logic signed [ACC_W-1:0] acc, acc_nx, out_q;
  logic [L:1]              vld_pipe;
  logic [L:1][PW-1:0]      pidx_pipe;
  logic signed [TW-1:0]    part [N];
  logic signed [TW-1:0]    lvl  [1:L][N];
  logic signed [TW-1:0]    tree_out;
  logic signed [XW-1:0]    sum_x, add_x;
  logic                    ovf_hit;

  assign issue    = (state == ISSUE);
  assign tree_out = lvl[L][0];

  for (genvar k = 0; k < N; k++) begin : g_lane
    spike_array_serial_acc_lane #(
      .WBITS(WBITS), .ABITS(ABITS), .PW(PW), .TW(TW)
    ) u_lane (
      .w    (w_q[k]),
      .a    (a_q[k]),
      .plane(cnt[PW-1:0]),
      .part (part[k])
    );
  end

  // Tree nodes are TW wide at every level so no stage can lose bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 1; s <= L; s++)
        for (int j = 0; j < N; j++) lvl[s][j] <= '0;
    end else begin
      for (int j = 0; j < N/2; j++) lvl[1][j] <= part[2*j] + part[2*j+1];
      for (int s = 2; s <= L; s++)
        for (int j = 0; j < (N >> s); j++) lvl[s][j] <= lvl[s-1][2*j] + lvl[s-1][2*j+1];
    end
  end

  always_comb begin
    sum_x   = {{(XW-TW){tree_out[TW-1]}}, tree_out};
    add_x   = {{(XW-ACC_W){acc[ACC_W-1]}}, acc} + (sum_x <<< pidx_pipe[L]);
    ovf_hit = !((&add_x[XW-1:ACC_W-1]) || !(|add_x[XW-1:ACC_W-1]));
    if (ovf_hit && SAT != 0)
      acc_nx = add_x[XW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_nx = add_x[ACC_W-1:0];
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE:  if (bus.in_valid && in_ready_q) begin
               accept   = 1'b1;
               state_nx = ISSUE;
             end
      ISSUE: if (cnt == CW'(ABITS-1)) state_nx = DRAIN;
      DRAIN: if (cnt == CW'(ABITS+L)) state_nx = last_q ? OUT : IDLE;
      OUT:   if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      w_q         <= '0;
      a_q         <= '0;
      last_q      <= 1'b0;
      dp_open     <= 1'b0;
      acc         <= '0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      vld_pipe    <= '0;
      pidx_pipe   <= '0;
    end else begin
      state       <= state_nx;
      in_ready_q  <= (state_nx == IDLE);
      out_valid_q <= (state_nx == OUT);
      vld_pipe[1]  <= issue;
      pidx_pipe[1] <= cnt[PW-1:0];
      for (int s = 2; s <= L; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        pidx_pipe[s] <= pidx_pipe[s-1];
      end
      if (accept) begin
        w_q     <= bus.i_weights_flat;
        a_q     <= bus.i_acts_flat;
        last_q  <= bus.in_last;
        dp_open <= 1'b1;
        cnt     <= '0;
        if (!dp_open) begin
          acc   <= '0;
          ovf_q <= 1'b0;
        end
      end else if (state == ISSUE || state == DRAIN) begin
        cnt <= cnt + 1'b1;
      end
      if (vld_pipe[L]) begin
        acc <= acc_nx;
        if (ovf_hit) ovf_q <= 1'b1;
      end
      if (state == DRAIN && state_nx == OUT) out_q <= acc;
      if (state == OUT && bus.out_ready) dp_open <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_spike_array_serial_acc.sv
// Directed bench: three arrays (24-bit saturating, 12-bit saturating, 12-bit wrapping)
// share one stimulus stream; expected results are hand-computed constants.
module tb_spike_array_serial_acc;
  localparam int N  = 128;
  localparam int WB = 4;
  localparam int AB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   lat;
  int   seen;

  always #5 clk = ~clk;

  spike_array_serial_acc_if #(.N(N), .WBITS(WB), .ABITS(AB), .ACC_W(24)) bus0 ();
  spike_array_serial_acc_if #(.N(N), .WBITS(WB), .ABITS(AB), .ACC_W(12)) bus1 ();
  spike_array_serial_acc_if #(.N(N), .WBITS(WB), .ABITS(AB), .ACC_W(12)) bus2 ();

  assign bus1.in_valid       = bus0.in_valid;
  assign bus1.in_last        = bus0.in_last;
  assign bus1.i_weights_flat = bus0.i_weights_flat;
  assign bus1.i_acts_flat    = bus0.i_acts_flat;
  assign bus1.out_ready      = bus0.out_ready;
  assign bus2.in_valid       = bus0.in_valid;
  assign bus2.in_last        = bus0.in_last;
  assign bus2.i_weights_flat = bus0.i_weights_flat;
  assign bus2.i_acts_flat    = bus0.i_acts_flat;
  assign bus2.out_ready      = bus0.out_ready;

  spike_array_serial_acc #(.N(N), .WBITS(WB), .ABITS(AB), .ACC_W(24), .SAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  spike_array_serial_acc #(.N(N), .WBITS(WB), .ABITS(AB), .ACC_W(12), .SAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  spike_array_serial_acc #(.N(N), .WBITS(WB), .ABITS(AB), .ACC_W(12), .SAT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] w, input logic [3:0] a, input logic last);
    for (int k = 0; k < N; k++) begin
      bus0.i_weights_flat[k*WB +: WB] = w;
      bus0.i_acts_flat[k*AB +: AB]    = a;
    end
    bus0.in_last = last;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input string tag);
    int n = 0;
    while (!bus0.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, bus0.in_ready, 1);
    bus0.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid = 1'b0;
  endtask

  // Counts edges until out_valid (sel=0) or in_ready (sel=1) is seen high
  task automatic wait_sig(input bit sel, output int n);
    n = 0;
    while (!(sel ? bus0.in_ready : bus0.out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    load(4'd0, 4'd0, 1'b0);

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus0.in_ready, 0);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_out_data", bus0.out_data, 0);
    chk("rst_ovf", bus0.ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus0.in_ready, 1);

    // 1: w=3, a=1 -> 384 at E0+12, held after handshake
    load(4'd3, 4'd1, 1'b1);
    send("t1");
    chk("t1_busy", bus0.in_ready, 0);
    wait_sig(1'b0, lat);
    chk("t1_lat", lat, 12);
    chk("t1_data", bus0.out_data, 384);
    chk("t1_ovf", bus0.ovf, 0);
    chk("t1_in_ready_out", bus0.in_ready, 0);
    @(negedge clk);
    chk("t1_hs_valid", bus0.out_valid, 0);
    chk("t1_hs_ready", bus0.in_ready, 1);
    chk("t1_hs_hold", bus0.out_data, 384);

    // 2: w=7, a=-8 -> plane 3 only, negative path
    load(4'd7, 4'b1000, 1'b1);
    send("t2");
    wait_sig(1'b0, lat);
    chk("t2_lat", lat, 12);
    chk("t2_data", bus0.out_data, -7168);
    chk("t2_ovf", bus0.ovf, 0);

    // 3: three vectors w=-8, a=7 accumulate into one result
    load(4'b1000, 4'd7, 1'b0);
    send("t3a");
    wait_sig(1'b1, lat);
    chk("t3a_busy", lat, 12);
    chk("t3a_no_out", bus0.out_valid, 0);
    send("t3b");
    wait_sig(1'b1, lat);
    chk("t3b_busy", lat, 12);
    chk("t3b_no_out", bus0.out_valid, 0);
    load(4'b1000, 4'd7, 1'b1);
    send("t3c");
    wait_sig(1'b0, lat);
    chk("t3c_lat", lat, 12);
    chk("t3_data", bus0.out_data, -21504);

    // 4: back-pressure holds the result; in_valid pulses are ignored
    @(negedge clk);
    bus0.out_ready = 1'b0;
    load(4'd3, 4'd1, 1'b1);
    send("t4");
    wait_sig(1'b0, lat);
    chk("t4_lat", lat, 12);
    load(4'd1, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus0.in_valid = (i % 2 == 0);
      @(negedge clk);
      chk("t4_hold_valid", bus0.out_valid, 1);
      chk("t4_hold_data", bus0.out_data, 384);
      chk("t4_hold_ready", bus0.in_ready, 0);
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs_valid", bus0.out_valid, 0);
    chk("t4_hs_ready", bus0.in_ready, 1);
    chk("t4_hs_hold", bus0.out_data, 384);
    repeat (3) @(negedge clk);
    chk("t4_no_start", bus0.in_ready, 1);

    // 5: w=-8, a=-8 -> +8192; 12-bit copies saturate / wrap
    load(4'b1000, 4'b1000, 1'b1);
    send("t5");
    wait_sig(1'b0, lat);
    chk("t5_wide_data", bus0.out_data, 8192);
    chk("t5_wide_ovf", bus0.ovf, 0);
    chk("t5_sat_data", bus1.out_data, 2047);
    chk("t5_sat_ovf", bus1.ovf, 1);
    chk("t5_wrap_data", bus2.out_data, 0);
    chk("t5_wrap_ovf", bus2.ovf, 1);
    @(negedge clk);
    chk("t5_ovf_sticky", bus1.ovf, 1);

    // ovf clears when the next dot product opens
    load(4'd1, 4'd1, 1'b1);
    send("t5b");
    chk("t5b_sat_ovf_clr", bus1.ovf, 0);
    chk("t5b_wrap_ovf_clr", bus2.ovf, 0);
    wait_sig(1'b0, lat);
    chk("t5b_sat_data", bus1.out_data, 128);

    // 6: reset during ISSUE aborts; next vector starts clean
    load(4'd3, 4'd1, 1'b1);
    send("t6");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus0.out_valid, 0);
    chk("t6_rst_ready", bus0.in_ready, 0);
    chk("t6_rst_data", bus0.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus0.out_valid) seen++;
    end
    chk("t6_no_out", seen, 0);
    load(4'd1, 4'd1, 1'b1);
    send("t6b");
    wait_sig(1'b0, lat);
    chk("t6b_lat", lat, 12);
    chk("t6b_data", bus0.out_data, 128);
    chk("t6b_ovf", bus0.ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
